// File: rtl/prog_feeder.sv
// ============================================================================
// prog_feeder : 16-word program buffer that feeds a 10-bit processor Data_in
// Rev 1.0
// ============================================================================
`default_nettype none

module prog_feeder #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 10
) (
    input  logic          CLK50M,
    input  logic          RSTb,
    input  logic [W-1:0]  SW,
    input  logic          LD,
    input  logic          RUN,
    input  logic          TAKEN,
    output logic [W-1:0]  DOUT,
    output logic          VALID,
    output logic [AW:0]   LEN,
    output logic [AW-1:0] RPTR,
    output logic          FULL,
    output logic          OVF,
    output logic          HALTED
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic          ovf_q, ovf_d;
    logic          ld_prev_q, run_prev_q;
    logic          ld_rise_q, run_rise_q;
    logic          mem_we;
    logic          is_last;
    logic [W-1:0]  mem_q [DEPTH];

    // Prev flops reset high so a key held through reset release yields no rise
    always_ff @(posedge CLK50M or negedge RSTb) begin
        if (!RSTb) begin
            ld_prev_q  <= 1'b1;
            run_prev_q <= 1'b1;
            ld_rise_q  <= 1'b0;
            run_rise_q <= 1'b0;
        end else begin
            ld_prev_q  <= LD;
            run_prev_q <= RUN;
            ld_rise_q  <= LD & ~ld_prev_q;
            run_rise_q <= RUN & ~run_prev_q;
        end
    end

    always_ff @(posedge CLK50M or negedge RSTb) begin
        if (!RSTb) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            rptr_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rptr_q  <= rptr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign is_last = (({1'b0, rptr_q} + (AW+1)'(1)) == len_q);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        rptr_d  = rptr_q;
        ovf_d   = ovf_q;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A run press always suppresses a coincident load
                if (run_rise_q) begin
                    if (len_q != '0) begin
                        state_d = ST_RUN;
                        rptr_d  = '0;
                    end
                end else if (ld_rise_q) begin
                    if (FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        len_d  = len_q + (AW+1)'(1);
                    end
                end
            end
            ST_RUN: begin
                if (run_rise_q) begin
                    state_d = ST_IDLE;
                end else if (TAKEN) begin
                    if (is_last) begin
                        state_d = ST_HALT;
                    end else begin
                        rptr_d = rptr_q + AW'(1);
                    end
                end
            end
            ST_HALT: begin
                if (run_rise_q) begin
                    state_d = ST_RUN;
                    rptr_d  = '0;
                end else if (ld_rise_q) begin
                    state_d = ST_IDLE;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK50M) begin
        if (mem_we) begin
            mem_q[len_q[AW-1:0]] <= SW;
        end
    end

    assign DOUT   = (state_q == ST_RUN) ? mem_q[rptr_q] : '0;
    assign VALID  = (state_q == ST_RUN);
    assign HALTED = (state_q == ST_HALT);
    assign LEN    = len_q;
    assign RPTR   = rptr_q;
    assign FULL   = (len_q == (AW+1)'(DEPTH));
    assign OVF    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_feeder.sv
// ============================================================================
// tb_prog_feeder : directed + random bench for prog_feeder with a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_prog_feeder;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;

    logic        CLK50M = 1'b0;
    logic        RSTb   = 1'b0;
    logic [9:0]  SW     = '0;
    logic        LD     = 1'b0;
    logic        RUN    = 1'b0;
    logic        TAKEN  = 1'b0;
    logic [9:0]  DOUT;
    logic        VALID;
    logic [4:0]  LEN;
    logic [3:0]  RPTR;
    logic        FULL;
    logic        OVF;
    logic        HALTED;

    int n_vec = 0;
    int n_err = 0;

    logic [9:0] m_prog [$];
    int         m_st  = S_IDLE;
    bit         m_ovf = 1'b0;
    int         m_ptr = 0;

    prog_feeder #(.DEPTH(16), .AW(4), .W(10)) dut (
        .CLK50M (CLK50M),
        .RSTb   (RSTb),
        .SW     (SW),
        .LD     (LD),
        .RUN    (RUN),
        .TAKEN  (TAKEN),
        .DOUT   (DOUT),
        .VALID  (VALID),
        .LEN    (LEN),
        .RPTR   (RPTR),
        .FULL   (FULL),
        .OVF    (OVF),
        .HALTED (HALTED)
    );

    always #10 CLK50M = ~CLK50M;

    // ---------------- reference model (event level) ----------------
    task automatic m_reset();
        m_prog.delete();
        m_st  = S_IDLE;
        m_ovf = 1'b0;
        m_ptr = 0;
    endtask

    task automatic m_ld(input logic [9:0] v);
        if (m_st == S_IDLE) begin
            if (m_prog.size() < 16) m_prog.push_back(v);
            else m_ovf = 1'b1;
        end else if (m_st == S_HALT) begin
            m_prog.delete();
            m_ovf = 1'b0;
            m_st  = S_IDLE;
        end
    endtask

    task automatic m_run();
        if (m_st == S_IDLE) begin
            if (m_prog.size() > 0) begin
                m_st  = S_RUN;
                m_ptr = 0;
            end
        end else if (m_st == S_RUN) begin
            m_st = S_IDLE;
        end else begin
            m_st  = S_RUN;
            m_ptr = 0;
        end
    endtask

    task automatic m_taken();
        if (m_st == S_RUN) begin
            if (m_ptr < m_prog.size() - 1) m_ptr++;
            else m_st = S_HALT;
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [9:0] e_dout;
        e_dout = (m_st == S_RUN) ? m_prog[m_ptr] : 10'h000;
        chk({tag, ".valid"},  32'(VALID),  32'(m_st == S_RUN));
        chk({tag, ".halted"}, 32'(HALTED), 32'(m_st == S_HALT));
        chk({tag, ".len"},    32'(LEN),    32'(m_prog.size()));
        chk({tag, ".full"},   32'(FULL),   32'(m_prog.size() == 16));
        chk({tag, ".ovf"},    32'(OVF),    32'(m_ovf));
        chk({tag, ".dout"},   32'(DOUT),   32'(e_dout));
        chk({tag, ".rptr"},   32'(RPTR),   32'(m_ptr));
    endtask

    // ---------------- stimulus helpers (entered/left on a falling edge) -------
    task automatic tick(input int n);
        repeat (n) @(negedge CLK50M);
    endtask

    task automatic press(input bit ld, input bit rn, input logic [9:0] v);
        int h;
        h   = $urandom_range(1, 4);
        SW  = v;
        LD  = ld;
        RUN = rn;
        tick(h);
        LD  = 1'b0;
        RUN = 1'b0;
        tick(2);
        if (rn) m_run();
        else if (ld) m_ld(v);
    endtask

    task automatic taken(input int n);
        TAKEN = 1'b1;
        repeat (n) begin
            tick(1);
            m_taken();
        end
        TAKEN = 1'b0;
    endtask

    // RUN rise lands on the same edge as a TAKEN pulse
    task automatic abort_taken();
        RUN = 1'b1;
        tick(1);
        TAKEN = 1'b1;
        tick(1);
        TAKEN = 1'b0;
        RUN   = 1'b0;
        tick(2);
        m_run();
    endtask

    initial begin
        // Reset state
        RSTb = 1'b0;
        tick(2);
        m_reset();
        check_all("reset");
        RSTb = 1'b1;
        tick(2);
        check_all("post_reset");

        // Load three words
        press(1, 0, 10'h155);
        press(1, 0, 10'h2AA);
        press(1, 0, 10'h003);
        check_all("load3");
        chk("load3.len_const", 32'(LEN), 32'd3);

        // Run through the program
        press(0, 1, 10'h000);
        check_all("run0");
        chk("run0.dout_const", 32'(DOUT), 32'h155);
        taken(1);
        chk("run1.dout_const", 32'(DOUT), 32'h2AA);
        taken(1);
        chk("run2.dout_const", 32'(DOUT), 32'h003);
        check_all("run2");
        taken(1);
        check_all("halt");
        chk("halt.halted_const", 32'(HALTED), 32'd1);

        // TAKEN outside RUN does nothing
        taken(1);
        check_all("halt_taken");

        // Re-run, back-to-back TAKEN, then clear from HALT
        press(0, 1, 10'h000);
        check_all("rerun");
        chk("rerun.dout_const", 32'(DOUT), 32'h155);
        taken(2);
        check_all("b2b");
        chk("b2b.rptr_const", 32'(RPTR), 32'd2);
        taken(1);
        press(1, 0, 10'h3FF);
        check_all("clear");
        chk("clear.len_const", 32'(LEN), 32'd0);

        // Overflow
        for (int i = 0; i < 17; i++) press(1, 0, 10'(i));
        check_all("ovf");
        chk("ovf.flag_const", 32'(OVF), 32'd1);
        press(0, 1, 10'h000);
        taken(15);
        check_all("ovf_last");
        chk("ovf_last.dout_const", 32'(DOUT), 32'h00F);
        taken(1);
        press(1, 0, 10'h000);
        check_all("ovf_clear");

        // Priority: coincident LD/RUN in IDLE, then abort against TAKEN
        press(1, 0, 10'h111);
        press(1, 0, 10'h222);
        press(1, 1, 10'h333);
        check_all("both_idle");
        chk("both_idle.len_const", 32'(LEN), 32'd2);
        abort_taken();
        check_all("abort");
        chk("abort.rptr_const", 32'(RPTR), 32'd0);

        // LD ignored during RUN
        press(0, 1, 10'h000);
        press(1, 0, 10'h0AA);
        check_all("ld_in_run");

        // Asynchronous reset mid-RUN
        #5 RSTb = 1'b0;
        #1 m_reset();
        check_all("async_rst");
        @(negedge CLK50M);
        RSTb = 1'b1;
        tick(1);

        // Key held through reset release
        LD   = 1'b1;
        RSTb = 1'b0;
        tick(2);
        RSTb = 1'b1;
        tick(4);
        check_all("held_ld");
        LD = 1'b0;
        tick(2);
        press(1, 0, 10'h0C3);
        check_all("held_ld_repress");

        // Randomized operation mix
        for (int k = 0; k < 300; k++) begin
            int op;
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2, 3: press(1, 0, 10'($urandom));
                4, 5:       press(0, 1, 10'($urandom));
                6, 7:       taken($urandom_range(1, 3));
                8:          press(1, 1, 10'($urandom));
                default: begin
                    if (m_st == S_RUN) abort_taken();
                    else taken(1);
                end
            endcase
            check_all($sformatf("rnd%0d", k));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prog_feeder.md
# prog_feeder

Program feeder that sits directly upstream of the 10-bit processor and drives its `Data_in` bus. The operator enters a short program from the slide switches, one 10-bit word per load-key press, into a 16-entry buffer. On a run-key press the block presents the stored words to the processor in order. It advances one word each time the processor signals that it has latched the current word, and halts after the last word.

## Interface
Parameters:
- `DEPTH`, 16: number of program words held.
- `AW`, 4: pointer width, log2(`DEPTH`).
- `W`, 10: data word width; matches the processor bus.

Ports:
- `CLK50M` in 1: 50 MHz system clock; all state changes on its rising edge.
- `RSTb` in 1: asynchronous, active-low reset.
- `SW` in `W`: switch data, written into the buffer on a load press.
- `LD` in 1: debounced load key, active-high level.
- `RUN` in 1: debounced run key, active-high level.
- `TAKEN` in 1: one-cycle pulse; the processor has latched the current `DOUT` word.
- `DOUT` out `W`: word presented to the processor `Data_in`.
- `VALID` out 1: `DOUT` holds a live program word.
- `LEN` out `AW+1`: number of stored words, 0..`DEPTH`.
- `RPTR` out `AW`: index of the word currently presented.
- `FULL` out 1: `LEN == DEPTH`.
- `OVF` out 1: sticky flag; a load was attempted while the buffer was full.
- `HALTED` out 1: the block is in state HALT.

## Operation
- Edge detect:
  - `LD` and `RUN` are each registered into a previous-level flop.
  - rise = level & ~prev.
  - The prev flops reset to 1, so a key held through reset release produces no rise.
- State machine, 2-bit encoding:
  - IDLE:
    - LD rise with `LEN < DEPTH`: write `SW` into mem[`LEN`], `LEN`++.
    - LD rise with `FULL`: no write; set `OVF`.
    - RUN rise with `LEN > 0`: go to RUN, `RPTR` = 0.
    - RUN rise with `LEN == 0`: ignored.
    - LD rise and RUN rise in the same cycle: RUN takes priority and no write occurs.
  - RUN:
    - `TAKEN` with `RPTR < LEN-1`: `RPTR`++.
    - `TAKEN` with `RPTR == LEN-1`: go to HALT.
    - RUN rise: abort to IDLE; program and `LEN` are kept. Abort beats a coincident `TAKEN`.
    - LD rise: ignored.
  - HALT:
    - RUN rise: go to RUN with `RPTR` = 0 (re-run the same program).
    - LD rise: go to IDLE, clear `LEN` and `OVF`, no write.
    - LD rise and RUN rise in the same cycle: RUN wins.
- Outputs:
  - `DOUT` = mem[`RPTR`] combinationally while in RUN; otherwise 0.
  - `VALID` = (state == RUN).
  - `HALTED` = (state == HALT).
- `TAKEN` is ignored outside RUN.
- Buffer contents are not reset; they are only readable after being written.
- `LEN` saturates at `DEPTH`; `RPTR` never wraps past `LEN-1`.

## Timing
- Reset, asynchronous:
  - state = IDLE; `LEN`, `RPTR`, `OVF` = 0.
  - `DOUT` = 0; `VALID`, `HALTED`, `FULL` = 0.
  - LD and RUN prev flops = 1.
- Reset asserted mid-RUN takes effect immediately: `VALID` drops the same instant and the program is lost.
- A key level first sampled high at edge k is registered as a rise at edge k. Its effect (write, `LEN`, state) is visible after edge k+1.
- `TAKEN` high at edge k: the new `RPTR` and `DOUT` are visible after edge k. `DOUT` changes within the same cycle with no extra read latency.
- Back-to-back `TAKEN` pulses on consecutive cycles each advance `RPTR` by one.
- A long key press produces exactly one rise.

## Test plan
- Reset then load: `SW` = 0x155, 0x2AA, 0x003 on three LD presses -> `LEN` = 3, `FULL` = 0, `VALID` = 0, `DOUT` = 0.
- Run: RUN press -> `VALID` = 1, `DOUT` = 0x155. Then `TAKEN` x2 -> `DOUT` = 0x2AA, then 0x003. A third `TAKEN` -> `HALTED` = 1, `VALID` = 0, `DOUT` = 0.
- Overflow: 17 LD presses with `SW` = index -> `LEN` = 16, `FULL` = 1, `OVF` = 1. In RUN, the last word presented is 0x00F.
- Priority: LD and RUN rise in the same cycle in IDLE with `LEN` = 2 -> state RUN, `LEN` stays 2. RUN rise coincident with `TAKEN` -> IDLE, `RPTR` not incremented.
- Held key through reset: `LD` = 1 while `RSTb` deasserts -> no write, `LEN` = 0. Release and press again -> `LEN` = 1.
- Re-run and clear: from HALT, RUN press -> `RPTR` = 0, `DOUT` = first word. From HALT, LD press -> IDLE, `LEN` = 0, `OVF` = 0.
